mcu_reg_bridge: RTL and testbench
=================================

MCU_REG_BRIDGE -- requirements
Module: mcu_reg_bridge

Interface
REQ-001 Parameter: ADDR_W, default 6, width of reg_addr, in bytes; bits 1:0 are always 0.
REQ-002 clk  input  1  sole clock; all logic is on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 spi_cs_n  input  1  MCU chip select, active low, asynchronous to clk.
REQ-005 spi_sck  input  1  MCU SPI clock in mode 0, asynchronous; period at least 8 clk periods.
REQ-006 spi_mosi  input  1  MCU serial data in, MSB first.
REQ-007 spi_miso  output  1  serial read data to MCU, MSB first.
REQ-008 reg_addr  output  ADDR_W  register byte address to the register target.
REQ-009 reg_wdata  output  32  write data to the register target.
REQ-010 reg_wstrobe  output  1  single-clk write pulse to the register target.
REQ-011 reg_rdata  input  32  combinational read data from the target for the current reg_addr.
REQ-012 xact_abort  output  1  single-clk pulse when a transaction is truncated by spi_cs_n rising.

Function
REQ-013 spi_cs_n, spi_sck and spi_mosi SHALL each pass through a 2-flop synchroniser; SCK rise/fall SHALL be detected from the synchronised signal, one clk pulse per edge.
REQ-014 Frame format: 8-bit command, then 32 data bits, all MSB first; command bit7 = 1 for write, 0 for read; command bits[ADDR_W-3:0] = word index; other command bits are ignored.
REQ-015 reg_addr SHALL be {cmd word index, 2'b00}, updated one clk after the 8th SCK rise, and held until the next command completes.
REQ-016 FSM states: IDLE, CMD, DATA, DONE.
REQ-017 IDLE->CMD on synchronised spi_cs_n falling; the bit counter is cleared.
REQ-018 CMD: MOSI is sampled on each SCK rise; after 8 bits -> DATA.
REQ-019 DATA, write: MOSI bits shift into a 32-bit shift register; after the 32nd SCK rise, reg_wdata loads the shift value and reg_wstrobe is high for exactly one clk on the next cycle; -> DONE.
REQ-020 DATA, read: on the clk after reg_addr updates, reg_rdata SHALL be captured into the shift register.
REQ-021 DATA, read: spi_miso SHALL present bit31 from the first SCK fall after the command, and shift to the next bit on each subsequent SCK fall; after the 32nd SCK rise -> DONE.
REQ-022 A read SHALL never assert reg_wstrobe.
REQ-023 spi_miso SHALL be 0 in IDLE, CMD, DONE, and during write DATA.
REQ-024 DONE: further SCK edges are ignored; no strobe or address change; -> IDLE on spi_cs_n rising.
REQ-025 spi_cs_n rising in CMD or DATA SHALL force IDLE with no reg_wstrobe, pulse xact_abort for one clk, and leave reg_addr/reg_wdata unchanged.
REQ-026 Each transaction requires a spi_cs_n high-low cycle; at most one register access occurs per frame.
REQ-027 Simultaneous spi_cs_n rise and the 32nd SCK rise in the same clk: abort takes priority and no strobe is issued.
REQ-028 The bit counter is 6 bits, counts 0..39, and does not wrap within a frame.

Reset
REQ-029 While reset is high, and immediately on its assertion, the module SHALL hold these values:
- state IDLE
- reg_addr 0
- reg_wdata 0
- reg_wstrobe 0
- spi_miso 0
- xact_abort 0
- synchronisers 2'b11 for cs_n, 0 for sck and mosi
- counters 0
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release, the remainder of that frame is ignored until spi_cs_n goes high then low.

Verification
REQ-031 Write: cmd 0x88, data 0xDEADBEEF -> reg_addr = 6'h20; exactly one reg_wstrobe pulse with reg_wdata = 0xDEADBEEF; no xact_abort.
REQ-032 Read: target returns 0x12345678 at reg_addr 6'h24; cmd 0x09 -> MCU shifts in 0x12345678; reg_wstrobe stays 0.
REQ-033 Abort: cmd 0x81, CS released after 20 data bits -> one xact_abort pulse, no reg_wstrobe, reg_wdata keeps its prior value.
REQ-034 Overlong frame: write cmd 0x80 + 0xA5A5A5A5 + 16 extra clocks -> exactly one strobe with 0xA5A5A5A5; extra bits ignored.
REQ-035 Reset mid-write after 12 data bits, then a full write 0x83/0x00000001 -> only the second write strobes, with reg_addr = 6'h0C.
REQ-036 SCK at exactly clk/8 with back-to-back frames (CS high for 4 clk) -> all frames complete correctly.

Source files
------------

// File: rtl/mcu_reg_bridge.sv
// SPI (mode 0) slave that turns one 40-bit MCU frame into a single 32-bit
// register write or read on a simple address/strobe register port.
module mcu_reg_bridge #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic              reg_wstrobe,
   input  logic [31:0]       reg_rdata,
   output logic              xact_abort
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CMD     = 2'd1;
   localparam logic [1:0] ST_DATA    = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;
   localparam logic [5:0] CMD_LAST   = 6'd7;
   localparam logic [5:0] FRAME_LAST = 6'd39;
   localparam int         IDX_W      = ADDR_W - 2;

   logic             cs_p0, cs_p1, cs_p2;
   logic             sck_p0, sck_p1, sck_p2;
   logic             mosi_p0, mosi_p1;
   logic             vld_p0, vld_p1;
   logic             cs_armed;
   logic [1:0]       state;
   logic [5:0]       bit_cnt;
   logic             is_wr;
   logic             rd_load;
   logic [IDX_W-1:0] idx_sr;
   logic [31:0]      data_sr;

   logic             sck_rise, sck_fall, cs_rise, cs_fall;
   logic             abort_now, cmd_shift, cmd_last;
   logic             data_rise, data_last, rd_fall;
   logic [IDX_W-1:0] idx_next;
   logic [31:0]      wr_next;

   assign sck_rise  = sck_p1 & ~sck_p2;
   assign sck_fall  = ~sck_p1 & sck_p2;
   assign cs_rise   = cs_p1 & ~cs_p2;
   assign cs_fall   = ~cs_p1 & cs_p2;

   assign abort_now = ((state == ST_CMD) || (state == ST_DATA)) && cs_rise;
   assign cmd_shift = (state == ST_CMD) && !cs_rise && sck_rise;
   assign cmd_last  = cmd_shift && (bit_cnt == CMD_LAST);
   assign data_rise = (state == ST_DATA) && !cs_rise && sck_rise;
   assign data_last = data_rise && (bit_cnt == FRAME_LAST);
   assign rd_fall   = (state == ST_DATA) && !cs_rise && !is_wr && !rd_load && sck_fall;

   // Only the low command bits survive the shift: the word index lands here
   assign idx_next  = {idx_sr[IDX_W-2:0], mosi_p1};
   assign wr_next   = {data_sr[30:0], mosi_p1};

   // Stage p0/p1: two-flop synchronisers; p2 keeps the previous sample for edges
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_p0   <= 1'b1;
         cs_p1   <= 1'b1;
         cs_p2   <= 1'b1;
         sck_p0  <= 1'b0;
         sck_p1  <= 1'b0;
         sck_p2  <= 1'b0;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         cs_p0   <= spi_cs_n;
         cs_p1   <= cs_p0;
         cs_p2   <= cs_p1;
         sck_p0  <= spi_sck;
         sck_p1  <= sck_p0;
         sck_p2  <= sck_p1;
         mosi_p0 <= spi_mosi;
         mosi_p1 <= mosi_p0;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
      end
   end

   // Frame control; cs_armed blocks a frame that was already running across reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         bit_cnt     <= 6'd0;
         is_wr       <= 1'b0;
         rd_load     <= 1'b0;
         cs_armed    <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= 32'd0;
         reg_wstrobe <= 1'b0;
         spi_miso    <= 1'b0;
         xact_abort  <= 1'b0;
      end else begin
         reg_wstrobe <= 1'b0;
         xact_abort  <= 1'b0;
         rd_load     <= 1'b0;
         if (vld_p1 && cs_p1) begin
            cs_armed <= 1'b1;
         end
         if (abort_now) begin
            state      <= ST_IDLE;
            xact_abort <= 1'b1;
            spi_miso   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall && cs_armed) begin
                     state   <= ST_CMD;
                     bit_cnt <= 6'd0;
                  end
               end
               ST_CMD: begin
                  if (cmd_shift) begin
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'd0) begin
                        is_wr <= mosi_p1;
                     end
                     if (cmd_last) begin
                        reg_addr <= {idx_next, 2'b00};
                        rd_load  <= ~is_wr;
                        state    <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (rd_fall) begin
                     spi_miso <= data_sr[31];
                  end
                  if (data_rise) begin
                     if (data_last) begin
                        state    <= ST_DONE;
                        spi_miso <= 1'b0;
                        if (is_wr) begin
                           reg_wdata   <= wr_next;
                           reg_wstrobe <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end
               end
               ST_DONE: begin
                  if (cs_rise) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Shift datapath: no reset, contents are only consumed under control qualifiers
   always_ff @(posedge clk) begin
      if (cmd_shift) begin
         idx_sr <= idx_next;
      end
      if (rd_load) begin
         data_sr <= reg_rdata;
      end else if (data_rise && is_wr) begin
         data_sr <= wr_next;
      end else if (rd_fall) begin
         data_sr <= {data_sr[30:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_mcu_reg_bridge.sv
// Bench for mcu_reg_bridge: an MCU-side SPI driver, a register target, and a
// frame-level reference model of which accesses each frame must produce.
module tb_mcu_reg_bridge;

   localparam int CLK = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_cs_n, spi_sck, spi_mosi, spi_miso;
   logic [5:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic        reg_wstrobe, xact_abort;

   typedef struct packed {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   logic [31:0] tgt_mem   [16];
   logic [31:0] model_mem [16];
   wr_t         exp_q [$];
   wr_t         cur;
   logic [5:0]  exp_addr;
   logic [31:0] exp_wdata;
   logic [31:0] last_rx;
   int          checks = 0, failures = 0;
   int          obs_aborts = 0, exp_aborts = 0, obs_strobes = 0;
   bit          in_read_data = 1'b0;

   always #(CLK/2) clk = ~clk;

   mcu_reg_bridge #(.ADDR_W(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_cs_n    (spi_cs_n),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_wstrobe (reg_wstrobe),
      .reg_rdata   (reg_rdata),
      .xact_abort  (xact_abort)
   );

   // Register target: combinational read, write on strobe
   assign reg_rdata = tgt_mem[reg_addr[5:2]];
   always @(posedge clk) begin
      if (!reset && reg_wstrobe) tgt_mem[reg_addr[5:2]] <= reg_wdata;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Per-cycle compare against the model's queue of expected writes
   always @(negedge clk) begin
      if (!reset) begin
         if (reg_wstrobe) begin
            obs_strobes++;
            chk("strobe_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               chk("strobe_addr", 64'(reg_addr), 64'(cur.a));
               chk("strobe_data", 64'(reg_wdata), 64'(cur.d));
            end
         end
         if (xact_abort) obs_aborts++;
         if (!in_read_data) chk("miso_quiet", 64'(spi_miso), 64'd0);
      end
   end

   task automatic send_bit(input logic b, input int h, output logic s);
      spi_mosi = b;
      #(h*CLK);
      spi_sck = 1'b1;
      s = spi_miso;
      #(h*CLK);
      spi_sck = 1'b0;
   endtask

   // One MCU frame of nbits SCK cycles; the model decides its outcome up front
   task automatic frame(input logic [7:0] cmd, input logic [31:0] data,
                        input int nbits, input int h, input int gap);
      logic [39:0] bits;
      logic [31:0] rx, exp_rd;
      logic        s;
      wr_t         e;
      bits   = {cmd, data};
      exp_rd = model_mem[cmd[3:0]];
      rx     = 32'd0;
      if (nbits >= 40 && cmd[7]) begin
         e.a = {cmd[3:0], 2'b00};
         e.d = data;
         exp_q.push_back(e);
      end
      spi_cs_n = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (i == 7 && !cmd[7]) in_read_data = 1'b1;
         send_bit((i < 40) ? bits[39-i] : 1'($urandom), h, s);
         if (i >= 8 && i < 40) rx = {rx[30:0], s};
      end
      #(h*CLK);
      spi_cs_n = 1'b1;
      if (nbits < 40) exp_aborts++;
      if (nbits >= 8) exp_addr = {cmd[3:0], 2'b00};
      if (nbits >= 40 && cmd[7]) begin
         exp_wdata = data;
         model_mem[cmd[3:0]] = data;
      end
      if (nbits >= 40 && !cmd[7]) chk("read_data", 64'(rx), 64'(exp_rd));
      last_rx = rx;
      #(4*CLK);
      in_read_data = 1'b0;
      #((gap-4)*CLK);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_addr"},    64'(reg_addr),     64'(exp_addr));
      chk({tag, "_wdata"},   64'(reg_wdata),    64'(exp_wdata));
      chk({tag, "_aborts"},  64'(obs_aborts),   64'(exp_aborts));
      chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_strobe"},  64'(reg_wstrobe),  64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_addr"},   64'(reg_addr),    64'd0);
      chk({tag, "_wdata"},  64'(reg_wdata),   64'd0);
      chk({tag, "_strobe"}, 64'(reg_wstrobe), 64'd0);
      chk({tag, "_miso"},   64'(spi_miso),    64'd0);
      chk({tag, "_abort"},  64'(xact_abort),  64'd0);
   endtask

   initial begin
      logic [7:0]  c;
      logic [31:0] d;
      logic        s;
      int          r, nb, strobes_before;

      reset    = 1'b1;
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tgt_mem[i]   = $urandom;
         model_mem[i] = tgt_mem[i];
      end
      exp_addr  = 6'd0;
      exp_wdata = 32'd0;
      last_rx   = 32'd0;

      repeat (3) @(posedge clk);
      #3;
      check_reset_values("reset");
      reset = 1'b0;
      #(6*CLK);

      // Plain write
      frame(8'h88, 32'hDEADBEEF, 40, 4, 6);
      chk("wr_addr",    64'(reg_addr),    64'h20);
      chk("wr_data",    64'(reg_wdata),   64'hDEADBEEF);
      chk("wr_strobes", 64'(obs_strobes), 64'd1);
      chk("wr_aborts",  64'(obs_aborts),  64'd0);

      // Plain read
      tgt_mem[9]   = 32'h12345678;
      model_mem[9] = 32'h12345678;
      frame(8'h09, 32'h0, 40, 4, 6);
      chk("rd_value",   64'(last_rx),     64'h12345678);
      chk("rd_addr",    64'(reg_addr),    64'h24);
      chk("rd_strobes", 64'(obs_strobes), 64'd1);

      // Write cut off after 20 data bits
      frame(8'h81, 32'h55555555, 28, 5, 6);
      chk("ab_aborts",  64'(obs_aborts),  64'd1);
      chk("ab_strobes", 64'(obs_strobes), 64'd1);
      chk("ab_wdata",   64'(reg_wdata),   64'hDEADBEEF);

      // Overlong write: 16 trailing clocks
      frame(8'h80, 32'hA5A5A5A5, 56, 4, 6);
      chk("ol_strobes", 64'(obs_strobes), 64'd2);
      chk("ol_wdata",   64'(reg_wdata),   64'hA5A5A5A5);
      chk("ol_addr",    64'(reg_addr),    64'h00);
      check_idle("directed");

      // Reset after 12 data bits, the rest of that frame must be ignored
      strobes_before = obs_strobes;
      spi_cs_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send_bit(((i < 8) ? 8'h83 : 8'hFF) >> (7 - ((i < 8) ? i : 0)) & 1'b1, 4, s);
      end
      reset = 1'b1;
      #(3*CLK);
      check_reset_values("midreset");
      reset = 1'b0;
      exp_addr  = 6'd0;
      exp_wdata = 32'd0;
      for (int i = 20; i < 40; i++) send_bit(1'b1, 4, s);
      #(4*CLK);
      spi_cs_n = 1'b1;
      #(6*CLK);
      check_idle("rst_tail");
      chk("rst_tail_strobes", 64'(obs_strobes), 64'(strobes_before));
      frame(8'h83, 32'h00000001, 40, 4, 6);
      chk("rst_wr_addr",    64'(reg_addr),    64'h0C);
      chk("rst_wr_data",    64'(reg_wdata),   64'h1);
      chk("rst_wr_strobes", 64'(obs_strobes), 64'(strobes_before + 1));

      // Back-to-back frames at clk/8 with a 4-clk CS gap
      frame(8'h8F, 32'hCAFEF00D, 40, 4, 4);
      frame(8'h0F, 32'h0,        40, 4, 4);
      chk("b2b_rd0", 64'(last_rx), 64'hCAFEF00D);
      frame(8'h82, 32'h0BADC0DE, 40, 4, 4);
      frame(8'h02, 32'h0,        40, 4, 4);
      chk("b2b_rd1", 64'(last_rx), 64'h0BADC0DE);
      frame(8'h4F, 32'h0,        40, 4, 4);
      chk("b2b_rd2", 64'(last_rx), 64'hCAFEF00D);
      #(4*CLK);
      check_idle("b2b");

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         c = 8'($urandom);
         d = $urandom;
         r = int'($urandom_range(0, 99));
         if (r < 70)      nb = 40;
         else if (r < 85) nb = int'($urandom_range(41, 56));
         else             nb = int'($urandom_range(0, 39));
         frame(c, d, nb, int'($urandom_range(4, 6)), int'($urandom_range(4, 8)));
         check_idle("rand");
      end

      #(10*CLK);
      check_idle("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
